// File: rtl/sha_padder.sv
// sha_padder: streams message bytes into SHA-1/SHA-2 blocks and applies the
// standard padding: a single 0x80 byte, zero fill, then the message bit length
// in the last L bytes of the final block. A length field that does not fit
// behind the 0x80 byte goes into an extra block.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, mode         begin a message (IDLE only); mode is latched here
//   in_valid/in_data/   byte input stream, big-endian order; in_last marks
//   in_last/in_ready    the final byte of the message
//   blk_valid/blk_ready block output handshake toward the hash engine
//   blk_new_msg         first block of a message
//   blk_mode            mode latched at start
//   blk_msg             padded block; byte k at [8*B-1-8k -: 8]
//   busy                high whenever the padder is not IDLE
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. While valid is high the payload is held stable, and valid does
// not depend combinationally on ready.

package sha;
    typedef enum logic [2:0] {
        sha1       = 3'd0,
        sha224     = 3'd1,
        sha256     = 3'd2,
        sha384     = 3'd3,
        sha512     = 3'd4,
        sha512_224 = 3'd5,
        sha512_256 = 3'd6
    } mode_t;
endpackage

module sha_padder #(
    parameter int CNT_W = 61
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  sha::mode_t    mode,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          blk_valid,
    output logic          blk_new_msg,
    output sha::mode_t    blk_mode,
    output logic [1023:0] blk_msg,
    input  logic          blk_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2,
        LEN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    sha::mode_t       mode_q, mode_d;
    logic [1023:0]    buf_q, buf_d;
    logic [6:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             final_q, final_d;
    logic             need_len_q, need_len_d;
    logic             pend80_q, pend80_d;

    logic             big;
    logic [6:0]       b_last;
    logic [6:0]       fit_max;
    logic [6:0]       pos;
    logic [CNT_W-1:0] cnt_inc;

    // Byte at stream position k lives at bit offset 8*(B-1-k); the caller
    // passes pos = B-1-k so this works for both block sizes.
    function automatic logic [1023:0] put_byte(input logic [1023:0] b,
                                               input logic [6:0]    p,
                                               input logic [7:0]    v);
        logic [1023:0] r;
        r = b;
        r[{p, 3'b000} +: 8] = v;
        return r;
    endfunction

    // The length field always ends at bit 0, so only its width differs.
    function automatic logic [1023:0] put_len(input logic [1023:0]    b,
                                              input logic             is_big,
                                              input logic [CNT_W-1:0] cnt);
        logic [1023:0] r;
        logic [127:0]  l;
        r = b;
        l = '0;
        l[CNT_W+2:0] = {cnt, 3'b000};
        if (is_big) begin
            r[127:0] = l;
        end else begin
            r[63:0] = l[63:0];
        end
        return r;
    endfunction

    always_comb begin
        big     = mode_q inside {sha::sha384, sha::sha512,
                                 sha::sha512_224, sha::sha512_256};
        b_last  = big ? 7'd127 : 7'd63;
        // Highest index for a last byte that still leaves room for 0x80
        // plus the full length field in the same block: B-2-L.
        fit_max = big ? 7'd110 : 7'd54;
        pos     = b_last - idx_q;
        cnt_inc = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        final_d    = final_q;
        need_len_d = need_len_q;
        pend80_d   = pend80_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    mode_d     = mode;
                    buf_d      = '0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    first_d    = 1'b1;
                    final_d    = 1'b0;
                    need_len_d = 1'b0;
                    pend80_d   = 1'b0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    buf_d = put_byte(buf_d, pos, in_data);
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        state_d = SEND;
                        if (idx_q == b_last) begin
                            // No room for 0x80: it opens the extra block.
                            pend80_d   = 1'b1;
                            need_len_d = 1'b1;
                        end else begin
                            buf_d = put_byte(buf_d, pos - 7'd1, 8'h80);
                            if (idx_q <= fit_max) begin
                                buf_d   = put_len(buf_d, big, cnt_inc);
                                final_d = 1'b1;
                            end else begin
                                need_len_d = 1'b1;
                            end
                        end
                    end else if (idx_q == b_last) begin
                        state_d = SEND;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            SEND: begin
                if (blk_ready) begin
                    first_d = 1'b0;
                    if (final_q) begin
                        state_d = IDLE;
                        final_d = 1'b0;
                    end else if (need_len_q) begin
                        state_d = LEN;
                    end else begin
                        state_d = FILL;
                        buf_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            LEN: begin
                // cnt_q already holds the full message byte count here.
                buf_d = '0;
                if (pend80_q) begin
                    buf_d = put_byte(buf_d, b_last, 8'h80);
                end
                buf_d      = put_len(buf_d, big, cnt_q);
                final_d    = 1'b1;
                need_len_d = 1'b0;
                pend80_d   = 1'b0;
                state_d    = SEND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= sha::sha1;
            buf_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            final_q    <= 1'b0;
            need_len_q <= 1'b0;
            pend80_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            final_q    <= final_d;
            need_len_q <= need_len_d;
            pend80_q   <= pend80_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign blk_valid   = (state_q == SEND);
    assign blk_new_msg = (state_q == SEND) && first_q;
    assign blk_mode    = mode_q;
    assign blk_msg     = buf_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sha_padder.sv
// Testbench for sha_padder: random and directed messages, reference padding
// computed from the message bytes, blocks checked as they leave the DUT.
module tb_sha_padder;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    sha::mode_t    mode = sha::sha1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          blk_valid;
    logic          blk_new_msg;
    sha::mode_t    blk_mode;
    logic [1023:0] blk_msg;
    logic          blk_ready = 1'b1;
    logic          busy;

    int total = 0;
    int bad = 0;

    // {new_msg, mode, block}
    logic [1027:0] exp_q[$];
    logic [1023:0] got_q[$];
    logic          got_nm[$];
    logic [7:0]    msg_q[$];
    int            ready_mode = 1; // 0 random, 1 always ready, 2 stalled

    sha_padder #(.CNT_W(61)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .blk_valid(blk_valid), .blk_new_msg(blk_new_msg),
        .blk_mode(blk_mode), .blk_msg(blk_msg), .blk_ready(blk_ready),
        .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- block-side ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       blk_ready = ($urandom_range(0, 3) != 0);
                1:       blk_ready = 1'b1;
                default: blk_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Standard SHA padding of msg_q: append 0x80, zero-fill until the stream
    // length is B-L mod B, then the bit length as L big-endian bytes.
    task automatic model_push(input sha::mode_t md);
        logic [7:0]    p[$];
        logic [127:0]  lb;
        logic [1023:0] blk;
        int            bsz;
        int            lsz;
        bit            is_big;
        is_big = md inside {sha::sha384, sha::sha512, sha::sha512_224, sha::sha512_256};
        bsz = is_big ? 128 : 64;
        lsz = is_big ? 16 : 8;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % bsz) != (bsz - lsz)) p.push_back(8'h00);
        lb = 128'(msg_q.size()) << 3;
        for (int k = 0; k < lsz; k++) p.push_back(lb[8*(lsz-1-k) +: 8]);
        for (int j = 0; j < p.size() / bsz; j++) begin
            blk = '0;
            for (int k = 0; k < bsz; k++) blk[8*bsz-1-8*k -: 8] = p[j*bsz+k];
            exp_q.push_back({(j == 0), md, blk});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [1027:0] got;
        logic [1027:0] want;
        int            fb;
        forever begin
            @(negedge clk);
            if (!rst && blk_valid && blk_ready) begin
                got = {blk_new_msg, blk_mode, blk_msg};
                got_q.push_back(blk_msg);
                got_nm.push_back(blk_new_msg);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL blk_unexpected: got block with new_msg=%0b mode=%0d, expected none",
                             blk_new_msg, blk_mode);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        fb = 0;
                        for (int k = 127; k >= 0; k--)
                            if (got[8*k +: 8] !== want[8*k +: 8]) fb = k;
                        $display("FAIL blk_cmp: new_msg=%0b/%0b mode=%0d/%0d byte_at_bit%0d got %02h expected %02h",
                                 got[1027], want[1027], got[1026:1024], want[1026:1024],
                                 8*fb, got[8*fb +: 8], want[8*fb +: 8]);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Sends one message; abort_at > 0 stops after that many bytes (nothing
    // is expected from an aborted message). Returns at posedge+#1.
    task automatic send_msg(input sha::mode_t md, input int len, input int abort_at,
                            input bit hello, input bit gaps);
        string s;
        int    n;
        s = "Hello World!";
        msg_q.delete();
        for (int i = 0; i < len; i++)
            msg_q.push_back(hello ? s[i] : 8'($urandom_range(0, 255)));
        if (abort_at == 0) model_push(md);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 5000);
        if (busy) begin
            chk("idle_wait_timeout", 128'(busy), 128'h0);
            return;
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = md;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = sha::mode_t'($urandom_range(0, 6));
        for (int i = 0; i < len; i++) begin
            if (abort_at != 0 && i == abort_at) return;
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = (i == len - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 5000);
            if (!in_ready) begin
                chk("in_ready_timeout", 128'(in_ready), 128'h1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 128'(n >= 5000), 128'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready), 128'h0);
        chk({tag, "_blk_valid"}, 128'(blk_valid), 128'h0);
        chk({tag, "_new_msg"},   128'(blk_new_msg), 128'h0);
        chk({tag, "_busy"},      128'(busy), 128'h0);
        chk({tag, "_mode"},      128'(blk_mode), 128'(sha::sha1));
        chk({tag, "_msg_zero"},  128'(blk_msg == '0), 128'h1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int            lens[8];
        logic [1023:0] cap;
        int            n;
        lens = '{55, 56, 63, 64, 111, 112, 127, 128};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "Hello World!" sha256
        ready_mode = 1;
        got_q.delete(); got_nm.delete();
        send_msg(sha::sha256, 12, 0, 1'b1, 1'b0);
        drain();
        chk("hw256_nblk", 128'(got_q.size()), 128'd1);
        if (got_q.size() == 1) begin
            chk("hw256_new", 128'(got_nm[0]), 128'h1);
            chk("hw256_b0", 128'(got_q[0][511:504]), 128'h48);
            chk("hw256_pad", 128'(got_q[0][415:408]), 128'h80);
            chk("hw256_len", 128'(got_q[0][63:0]), 128'h60);
            chk("hw256_hi0", 128'(got_q[0][1023:512] == '0), 128'h1);
        end

        // "Hello World!" sha512
        got_q.delete(); got_nm.delete();
        send_msg(sha::sha512, 12, 0, 1'b1, 1'b0);
        drain();
        chk("hw512_nblk", 128'(got_q.size()), 128'd1);
        if (got_q.size() == 1) begin
            chk("hw512_b0", 128'(got_q[0][1023:1016]), 128'h48);
            chk("hw512_pad", 128'(got_q[0][927:920]), 128'h80);
            chk("hw512_len", got_q[0][127:0], 128'h60);
        end

        // 56 bytes sha256: length spills into a second block
        got_q.delete(); got_nm.delete();
        send_msg(sha::sha256, 56, 0, 1'b0, 1'b1);
        drain();
        chk("m56_nblk", 128'(got_q.size()), 128'd2);
        if (got_q.size() == 2) begin
            chk("m56_pad", 128'(got_q[0][511-8*56 -: 8]), 128'h80);
            chk("m56_new0", 128'(got_nm[0]), 128'h1);
            chk("m56_new1", 128'(got_nm[1]), 128'h0);
            chk("m56_blk1_len", 128'(got_q[1][63:0]), 128'h1C0);
            chk("m56_blk1_zero", 128'(got_q[1][1023:64] == '0), 128'h1);
        end

        // 64 bytes sha224: 0x80 opens the extra block
        got_q.delete(); got_nm.delete();
        send_msg(sha::sha224, 64, 0, 1'b0, 1'b1);
        drain();
        chk("m64_nblk", 128'(got_q.size()), 128'd2);
        if (got_q.size() == 2) begin
            chk("m64_pad", 128'(got_q[1][511:504]), 128'h80);
            chk("m64_len", 128'(got_q[1][63:0]), 128'h200);
        end

        // Backpressure: hold blk_ready low while a block is offered
        ready_mode = 2;
        send_msg(sha::sha256, 12, 0, 1'b0, 1'b0);
        n = 0;
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 128'(blk_valid), 128'h1);
        cap = blk_msg;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_hold", 128'(blk_valid), 128'h1);
            chk("bp_msg_stable", 128'(blk_msg == cap), 128'h1);
            chk("bp_in_ready_low", 128'(in_ready), 128'h0);
        end
        ready_mode = 1;
        drain();

        // Reset mid-message
        got_q.delete(); got_nm.delete();
        send_msg(sha::sha256, 100, 30, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_blk", 128'(got_q.size()), 128'd0);
        send_msg(sha::sha256, 12, 0, 1'b1, 1'b0);
        drain();
        chk("after_rst_nblk", 128'(got_q.size()), 128'd1);
        if (got_q.size() == 1) chk("after_rst_new", 128'(got_nm[0]), 128'h1);

        // Boundary lengths and random traffic with random backpressure
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            send_msg(sha::mode_t'(i % 7), lens[i], 0, 1'b0, 1'b1);
            send_msg(sha::mode_t'((i + 3) % 7), lens[i], 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++)
            send_msg(sha::mode_t'($urandom_range(0, 6)), $urandom_range(1, 300), 0, 1'b0,
                     1'($urandom_range(0, 1)));
        drain();
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_padder.md
SHA_PADDER -- requirements
Module: sha_padder

Interface
REQ-001 Parameter CNT_W, default 61, width of the message byte counter; the length field carries CNT_W+3 significant bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new message; sampled only in IDLE.
REQ-005 mode  input  sha::mode_t  hash mode; latched when start is accepted.
REQ-006 in_valid  input  1  in_data holds a valid message byte.
REQ-007 in_data  input  8  message byte, big-endian stream order.
REQ-008 in_last  input  1  qualifies the final byte of the message.
REQ-009 in_ready  output  1  padder accepts a byte this cycle.
REQ-010 blk_valid  output  1  blk_msg holds a complete padded block.
REQ-011 blk_new_msg  output  1  high with blk_valid on the first block of a message only.
REQ-012 blk_mode  output  sha::mode_t  latched mode, driven with every block.
REQ-013 blk_msg  output  1024  padded block, engine layout.
REQ-014 blk_ready  input  1  sha_engine ready; a block transfers on a rising edge with blk_valid=1 and blk_ready=1.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Block size B SHALL be 64 bytes with an 8-byte length field L for sha1, sha224 and sha256, and 128 bytes with a 16-byte L for sha384, sha512, sha512_224 and sha512_256.
REQ-017 Byte k of a block SHALL occupy blk_msg[8*B-1-8k -: 8]; for 64-byte modes blk_msg[1023:512] SHALL be zero.
REQ-018 States SHALL be IDLE, FILL, SEND and LEN.
  - IDLE->FILL on start: latch mode, clear buffer, byte index and byte count, set first=1.
  - FILL->SEND on the acceptance of byte B-1 or of an in_last byte.
  - SEND->FILL, LEN or IDLE on block transfer.
  - LEN->SEND after one cycle.
REQ-019 in_ready SHALL be 1 only in FILL; one byte is accepted per edge with in_valid=1 and in_ready=1.
REQ-020 An accepted non-last byte SHALL be written at the byte index; the index and the count then increment.
REQ-021 On the edge accepting an in_last byte at index i, the padder SHALL write the byte and write 0x80 at i+1.
  - If B-(i+2) >= L, it SHALL also write the bit length, (count+1)*8 zero-extended to L bytes, into the last L bytes, and mark the block final.
  - Otherwise it SHALL mark the block as needing an extra length block.
REQ-022 When an in_last byte lands at index B-1, the 0x80 byte SHALL go at byte 0 of the extra block.
REQ-023 The extra block SHALL contain zeros, the 0x80 byte if still pending, and the length field in its last L bytes; it is built in LEN.
REQ-024 blk_valid SHALL rise in the cycle after the edge that completes a block.
  - blk_valid, blk_msg, blk_mode and blk_new_msg SHALL stay stable until transfer.
  - blk_valid SHALL drop in the cycle after transfer.
REQ-025 After transfer the next state SHALL be:
  - IDLE if the block was final;
  - LEN if an extra block is needed;
  - FILL with buffer cleared, index 0 and first=0 otherwise.
REQ-026 blk_new_msg SHALL equal first, and first SHALL clear after the first transfer.
REQ-027 start outside IDLE, and in_valid outside FILL, SHALL be ignored.
REQ-028 Zero-length messages are unsupported; every message carries at least one byte with in_last.
REQ-029 The byte counter SHALL wrap modulo 2^CNT_W without error indication.

Reset
REQ-030 While rst=1, asynchronously:
  - state=IDLE;
  - in_ready=0, blk_valid=0, blk_new_msg=0, busy=0;
  - blk_mode=sha::sha1, blk_msg=0;
  - counters, index and first all 0.
REQ-031 Reset asserted mid-message SHALL discard the partial block and the pending extra block, and SHALL emit nothing further.
REQ-032 The first start after reset release SHALL be accepted normally.

Verification
REQ-033 "Hello World!" (12 bytes), sha256, blk_ready=1 -> one block:
  - blk_new_msg=1, blk_msg[511:504]=0x48, [415:408]=0x80, [63:0]=0x60, [1023:512]=0;
  - block equals the engine's expected input for hash 7f83b165...9069.
REQ-034 Same string, sha512 -> one block with [1023:1016]=0x48, [927:920]=0x80, [127:0]=0x60.
REQ-035 56-byte message, sha256 -> two blocks:
  - first: byte 56=0x80, new_msg=1;
  - second: all zero except [63:0]=0x1C0, new_msg=0.
REQ-036 64-byte message, sha224 -> two blocks; the second has [511:504]=0x80, [63:0]=0x200.
REQ-037 Backpressure: blk_ready held 0 for 5 cycles -> blk_valid stays 1, blk_msg stays stable and in_ready stays 0 until blk_ready=1.
REQ-038 rst pulsed after 30 of 100 bytes -> all outputs return to reset values immediately, no block is emitted, and a following 12-byte message pads correctly with new_msg=1.
